sram_rec_ctrl: RTL and testbench
================================

SRAM_REC_CTRL -- requirements
Module: sram_rec_ctrl

Interface
REQ-001 Parameter ACCESS_CYC, default 2, cycles r/w are held per SRAM access (legal 1..15).
REQ-002 Parameter MAX_ADDR, default 18'h3FFFF, last usable SRAM word address.
REQ-003 clk  in  1  single clock; all logic on rising edge.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 start_rec  in  1  one-cycle pulse, begin recording at address 0.
REQ-006 start_play  in  1  one-cycle pulse, begin playback from address 0.
REQ-007 stop  in  1  one-cycle pulse, end current record/play.
REQ-008 samp_valid  in  1  record sample strobe; samp_in valid this cycle.
REQ-009 samp_in  in  16  record sample.
REQ-010 samp_req  in  1  playback consumer requests next sample.
REQ-011 samp_out  out  16  playback sample.
REQ-012 samp_out_valid  out  1  one-cycle strobe, samp_out valid.
REQ-013 addr  out  18  to SRAM stage addr_i.
REQ-014 r  out  1  to SRAM stage read request.
REQ-015 w  out  1  to SRAM stage write request.
REQ-016 wr_data  out  16  write data toward SRAM stage data bus.
REQ-017 rd_data  in  16  read data from SRAM stage data bus.
REQ-018 rec_len  out  19  samples in last recording (0..MAX_ADDR+1).
REQ-019 busy  out  1  high in any state except IDLE.
REQ-020 full  out  1  sticky, recording stopped because MAX_ADDR was written.
REQ-021 overrun  out  1  sticky, a samp_valid was dropped during a write.
REQ-022 done  out  1  one-cycle pulse when record or play returns to IDLE.

Function
REQ-023 FSM states IDLE, REC_WAIT, REC_WR, PLAY_WAIT, PLAY_RD; internal 18-bit address counter cnt; addr = cnt at all times.
REQ-024 r and w never high simultaneously; both low in IDLE, REC_WAIT, PLAY_WAIT.
REQ-025 IDLE + start_rec: cnt<=0, rec_len<=0, full<=0, overrun<=0, -> REC_WAIT; start_rec and start_play together: record wins.
REQ-026 IDLE + start_play: rec_len>0 -> cnt<=0, -> PLAY_WAIT; rec_len==0 -> stay IDLE, no done pulse.
REQ-027 start_rec/start_play outside IDLE ignored.
REQ-028 REC_WAIT + samp_valid at cycle t: wr_data<=samp_in, -> REC_WR; w high cycles t+1..t+ACCESS_CYC, addr and wr_data stable throughout.
REQ-029 End of REC_WR: rec_len<=cnt+1; if cnt==MAX_ADDR -> full<=1, done, IDLE (no wrap); else cnt<=cnt+1, -> REC_WAIT.
REQ-030 samp_valid while in REC_WR: sample dropped, overrun<=1.
REQ-031 PLAY_WAIT + samp_req at cycle t: -> PLAY_RD; r high cycles t+1..t+ACCESS_CYC; rd_data sampled at end of last r cycle; samp_out/samp_out_valid at t+ACCESS_CYC+1.
REQ-032 End of PLAY_RD: cnt+1==rec_len -> done, IDLE; else cnt<=cnt+1, -> PLAY_WAIT.
REQ-033 samp_req while in PLAY_RD ignored (not queued).
REQ-034 stop in REC_WAIT/PLAY_WAIT: -> IDLE next cycle with done.
REQ-035 stop in REC_WR/PLAY_RD: latched; access completes in full (incl. rec_len update / samp_out_valid), then IDLE with done.
REQ-036 samp_out holds last value until next read; rec_len, full, overrun hold in IDLE.

Reset
REQ-037 rst overrides all inputs incl. mid-access; next cycle: state IDLE, cnt=0, addr=0, r=0, w=0, wr_data=0, samp_out=0, samp_out_valid=0, rec_len=0, busy=0, full=0, overrun=0, done=0.
REQ-038 Access interrupted by reset is abandoned; no rec_len update, no samp_out_valid.

Verification (ACCESS_CYC=2)
REQ-039 start_rec, samp_valid with 16'h1234, 16'hABCD, then stop -> w high 2 cycles at addr 0 then addr 1 with those data, rec_len=2, one done pulse.
REQ-040 after REQ-039, start_play, samp_req x3 -> r 2 cycles at addr 0, 1; samp_out 16'h1234, 16'hABCD each with valid 3 cycles after samp_req; IDLE + done after second read; third samp_req ignored.
REQ-041 MAX_ADDR=3, start_rec, 5 samp_valid spaced 4 cycles -> writes at addr 0..3 only, full=1, rec_len=4, IDLE, addr never wraps to 0 with w high.
REQ-042 samp_valid on consecutive cycles -> second sample dropped, overrun=1, only first written.
REQ-043 rst asserted during w high -> next cycle w=0, IDLE, rec_len=0; start_play after rst -> stays IDLE.
REQ-044 start_rec and start_play same cycle in IDLE -> REC_WAIT; start_play during recording -> no effect, r stays 0.

Source files
------------

// File: rtl/sram_rec_ctrl.sv
// Record/playback sequencer for a 16-bit sample stream on an external SRAM stage.
// Every SRAM access holds r or w for ACCESS_CYC cycles while addr stays on the word counter.
module sram_rec_ctrl #(
  parameter int          ACCESS_CYC = 2,
  parameter logic [17:0] MAX_ADDR   = 18'h3FFFF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_rec,
  input  logic        start_play,
  input  logic        stop,
  input  logic        samp_valid,
  input  logic [15:0] samp_in,
  input  logic        samp_req,
  output logic [15:0] samp_out,
  output logic        samp_out_valid,
  output logic [17:0] addr,
  output logic        r,
  output logic        w,
  output logic [15:0] wr_data,
  input  logic [15:0] rd_data,
  output logic [18:0] rec_len,
  output logic        busy,
  output logic        full,
  output logic        overrun,
  output logic        done
);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_REC_WAIT  = 3'd1;
  localparam logic [2:0] S_REC_WR    = 3'd2;
  localparam logic [2:0] S_PLAY_WAIT = 3'd3;
  localparam logic [2:0] S_PLAY_RD   = 3'd4;

  localparam logic [3:0] TMR_LOAD = 4'(ACCESS_CYC - 1);

  logic [2:0]  r_state;
  logic [17:0] r_cnt;
  logic [3:0]  r_tmr;
  logic        r_stop_pend;
  logic [15:0] r_wr_data;
  logic [15:0] r_samp_out;
  logic        r_samp_out_valid;
  logic [18:0] r_rec_len;
  logic        r_full;
  logic        r_overrun;
  logic        r_done;

  logic [18:0] w_cnt_inc;
  logic        w_last_cyc;
  logic        w_end_req;

  assign w_cnt_inc  = {1'b0, r_cnt} + 19'd1;
  assign w_last_cyc = (r_tmr == 4'd0);
  // a stop seen on the final access cycle counts just like one latched earlier
  assign w_end_req  = r_stop_pend | stop;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state          <= S_IDLE;
      r_cnt            <= '0;
      r_tmr            <= '0;
      r_stop_pend      <= 1'b0;
      r_wr_data        <= '0;
      r_samp_out       <= '0;
      r_samp_out_valid <= 1'b0;
      r_rec_len        <= '0;
      r_full           <= 1'b0;
      r_overrun        <= 1'b0;
      r_done           <= 1'b0;
    end else begin
      r_done           <= 1'b0;
      r_samp_out_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_stop_pend <= 1'b0;
          if (start_rec) begin
            r_cnt     <= '0;
            r_rec_len <= '0;
            r_full    <= 1'b0;
            r_overrun <= 1'b0;
            r_state   <= S_REC_WAIT;
          end else if (start_play && (r_rec_len != 19'd0)) begin
            r_cnt   <= '0;
            r_state <= S_PLAY_WAIT;
          end
        end
        S_REC_WAIT: begin
          if (stop) begin
            r_done  <= 1'b1;
            r_state <= S_IDLE;
          end else if (samp_valid) begin
            r_wr_data <= samp_in;
            r_tmr     <= TMR_LOAD;
            r_state   <= S_REC_WR;
          end
        end
        S_REC_WR: begin
          if (samp_valid) r_overrun <= 1'b1;
          if (stop) r_stop_pend <= 1'b1;
          if (w_last_cyc) begin
            r_rec_len <= w_cnt_inc;
            if (r_cnt == MAX_ADDR) begin
              r_full  <= 1'b1;
              r_done  <= 1'b1;
              r_state <= S_IDLE;
            end else if (w_end_req) begin
              r_done  <= 1'b1;
              r_state <= S_IDLE;
            end else begin
              r_cnt   <= r_cnt + 18'd1;
              r_state <= S_REC_WAIT;
            end
          end else begin
            r_tmr <= r_tmr - 4'd1;
          end
        end
        S_PLAY_WAIT: begin
          if (stop) begin
            r_done  <= 1'b1;
            r_state <= S_IDLE;
          end else if (samp_req) begin
            r_tmr   <= TMR_LOAD;
            r_state <= S_PLAY_RD;
          end
        end
        S_PLAY_RD: begin
          if (stop) r_stop_pend <= 1'b1;
          if (w_last_cyc) begin
            r_samp_out       <= rd_data;
            r_samp_out_valid <= 1'b1;
            if ((w_cnt_inc == r_rec_len) || w_end_req) begin
              r_done  <= 1'b1;
              r_state <= S_IDLE;
            end else begin
              r_cnt   <= r_cnt + 18'd1;
              r_state <= S_PLAY_WAIT;
            end
          end else begin
            r_tmr <= r_tmr - 4'd1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign addr           = r_cnt;
  assign w              = (r_state == S_REC_WR);
  assign r              = (r_state == S_PLAY_RD);
  assign busy           = (r_state != S_IDLE);
  assign wr_data        = r_wr_data;
  assign samp_out       = r_samp_out;
  assign samp_out_valid = r_samp_out_valid;
  assign rec_len        = r_rec_len;
  assign full           = r_full;
  assign overrun        = r_overrun;
  assign done           = r_done;

endmodule

// File: tb/tb_sram_rec_ctrl.sv
// Scoreboard bench for sram_rec_ctrl: session-level stimulus pushes expected SRAM
// writes, playback samples and done pulses; a negedge monitor pops and compares them.
module tb_sram_rec_ctrl;

  localparam int          AC    = 2;
  localparam logic [17:0] MAXA  = 18'd3;
  localparam int          DEPTH = 4;

  localparam int K_WR   = 0;
  localparam int K_RD   = 1;
  localparam int K_DONE = 2;

  logic        clk;
  logic        rst;
  logic        start_rec, start_play, stop, samp_valid, samp_req;
  logic [15:0] samp_in, samp_out, wr_data, rd_data;
  logic        samp_out_valid, r, w, busy, full, overrun, done;
  logic [17:0] addr;
  logic [18:0] rec_len;

  // SRAM stage stand-in: combinational read of the words written so far
  logic [15:0] sram [DEPTH];
  assign rd_data = (addr < 18'(DEPTH)) ? sram[addr[1:0]] : 16'hDEAD;
  always @(posedge clk) if (w && (addr < 18'(DEPTH))) sram[addr[1:0]] <= wr_data;

  sram_rec_ctrl #(.ACCESS_CYC(AC), .MAX_ADDR(MAXA)) dut (
    .clk(clk), .rst(rst), .start_rec(start_rec), .start_play(start_play), .stop(stop),
    .samp_valid(samp_valid), .samp_in(samp_in), .samp_req(samp_req),
    .samp_out(samp_out), .samp_out_valid(samp_out_valid), .addr(addr), .r(r), .w(w),
    .wr_data(wr_data), .rd_data(rd_data), .rec_len(rec_len), .busy(busy), .full(full),
    .overrun(overrun), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          kind;
    int          addr;
    logic [15:0] data;
  } exp_t;

  exp_t        sb[$];
  logic [15:0] fixed_q[$];
  logic [15:0] mem[DEPTH];
  int          rec_len_m = 0;
  int          t = 0;
  int          n_tests = 0;
  int          n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0d)", name, act, exp, t);
    end
  endtask

  task automatic pop(input int kind, input string name, output exp_t e, output bit ok);
    ok = 1'b0;
    if (sb.size() == 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s_unexpected: got event kind %0d, expected no event (t=%0d)", name, kind, t);
    end else begin
      e = sb.pop_front();
      chk({name, "_kind"}, 32'(kind), 32'(e.kind));
      ok = (e.kind == kind);
    end
  endtask

  // monitor
  int          wrun = 0, rrun = 0, last_r_len = 0;
  logic [17:0] w_a, r_a, last_r_a;
  logic [15:0] w_d;
  bit          w_unstable, mon_ok;
  exp_t        mon_e;

  always @(negedge clk) begin
    if (rst) begin
      wrun = 0;
      rrun = 0;
    end else begin
      chk("r_w_exclusive", 32'(r & w), 32'd0);
      if (w) begin
        if (wrun == 0) begin
          w_a = addr; w_d = wr_data; w_unstable = 1'b0;
        end else if (addr !== w_a || wr_data !== w_d) begin
          w_unstable = 1'b1;
        end
        wrun++;
      end else if (wrun > 0) begin
        pop(K_WR, "wr", mon_e, mon_ok);
        if (mon_ok) begin
          chk("wr_addr", 32'(w_a), 32'(mon_e.addr));
          chk("wr_data", 32'(w_d), 32'(mon_e.data));
          chk("wr_len", 32'(wrun), 32'(AC));
          chk("wr_stable", 32'(w_unstable), 32'd0);
        end
        wrun = 0;
      end
      if (r) begin
        if (rrun == 0) r_a = addr;
        rrun++;
      end else if (rrun > 0) begin
        last_r_a = r_a; last_r_len = rrun; rrun = 0;
      end
      if (samp_out_valid) begin
        pop(K_RD, "rd", mon_e, mon_ok);
        if (mon_ok) begin
          chk("rd_data", 32'(samp_out), 32'(mon_e.data));
          chk("rd_addr", 32'(last_r_a), 32'(mon_e.addr));
          chk("rd_len", 32'(last_r_len), 32'(AC));
        end
      end
      if (done) pop(K_DONE, "done", mon_e, mon_ok);
    end
  end

  task automatic clk1();
    @(posedge clk);
    #1;
    t++;
    start_rec = 0; start_play = 0; stop = 0; samp_valid = 0; samp_req = 0;
  endtask

  task automatic chk_reset_vals();
    chk("rst_busy", 32'(busy), 0);       chk("rst_addr", 32'(addr), 0);
    chk("rst_r", 32'(r), 0);             chk("rst_w", 32'(w), 0);
    chk("rst_wr_data", 32'(wr_data), 0); chk("rst_samp_out", 32'(samp_out), 0);
    chk("rst_valid", 32'(samp_out_valid), 0);
    chk("rst_rec_len", 32'(rec_len), 0); chk("rst_full", 32'(full), 0);
    chk("rst_overrun", 32'(overrun), 0); chk("rst_done", 32'(done), 0);
  endtask

  // mode 0: spaced samples, 1: random spacing, 2: back-to-back
  task automatic rec_session(input int n, input int mode);
    int acc = 0, t_free, gap;
    bit ovr = 0;
    logic [15:0] d;
    start_rec = 1; start_play = 1'($urandom_range(0, 1));
    clk1();
    t_free = t;
    for (int i = 0; i < n; i++) begin
      case (mode)
        0:       gap = ((t_free > t) ? t_free - t : 0) + $urandom_range(0, 2);
        1:       gap = $urandom_range(0, AC + 1);
        default: gap = 0;
      endcase
      repeat (gap) clk1();
      d = (fixed_q.size() > 0) ? fixed_q.pop_front() : 16'($urandom);
      if (t >= t_free && acc < DEPTH) begin
        sb.push_back('{kind: K_WR, addr: acc, data: d});
        mem[acc] = d;
        acc++;
        t_free = t + AC + 1;
        if (acc == DEPTH) sb.push_back('{kind: K_DONE, addr: 0, data: 16'h0});
        start_play = 1'($urandom_range(0, 1));
      end else if (t < t_free) begin
        ovr = 1;
      end
      samp_valid = 1; samp_in = d;
      clk1();
    end
    repeat ($urandom_range(0, AC + 1)) clk1();
    stop = 1;
    if (acc < DEPTH) sb.push_back('{kind: K_DONE, addr: 0, data: 16'h0});
    clk1();
    repeat (AC + 3) clk1();
    chk("rec_busy", 32'(busy), 0);
    chk("rec_len", 32'(rec_len), 32'(acc));
    chk("rec_full", 32'(full), 32'(acc == DEPTH));
    chk("rec_overrun", 32'(overrun), 32'(ovr));
    rec_len_m = acc;
  endtask

  task automatic play_session(input int nreq, input int mode);
    int rd = 0, t_free, gap;
    start_play = 1;
    clk1();
    if (rec_len_m == 0) begin
      chk("play_empty_busy", 32'(busy), 0);
      clk1();
      return;
    end
    t_free = t;
    for (int i = 0; i < nreq; i++) begin
      gap = (mode == 0) ? ((t_free > t) ? t_free - t : 0) + $urandom_range(0, 2)
                        : $urandom_range(0, AC + 1);
      repeat (gap) clk1();
      if (t >= t_free && rd < rec_len_m) begin
        sb.push_back('{kind: K_RD, addr: rd, data: mem[rd]});
        rd++;
        t_free = t + AC + 1;
        if (rd == rec_len_m) sb.push_back('{kind: K_DONE, addr: 0, data: 16'h0});
        start_rec = 1'($urandom_range(0, 1));
      end
      samp_req = 1;
      clk1();
    end
    if (rd < rec_len_m) begin
      repeat ($urandom_range(0, AC + 1)) clk1();
      stop = 1;
      sb.push_back('{kind: K_DONE, addr: 0, data: 16'h0});
      clk1();
    end
    repeat (AC + 3) clk1();
    chk("play_busy", 32'(busy), 0);
    if (rd > 0) chk("samp_out_hold", 32'(samp_out), 32'(mem[rd-1]));
    chk("play_rec_len_hold", 32'(rec_len), 32'(rec_len_m));
  endtask

  task automatic reset_mid_write();
    start_rec = 1;
    clk1();
    samp_valid = 1; samp_in = 16'h5A5A;
    clk1();
    chk("w_before_rst", 32'(w), 1);
    rst = 1;
    clk1();
    rst = 0;
    chk_reset_vals();
    rec_len_m = 0;
    start_play = 1;
    clk1();
    chk("play_after_rst_busy", 32'(busy), 0);
    clk1();
  endtask

  initial begin
    rst = 1; start_rec = 0; start_play = 0; stop = 0; samp_valid = 0; samp_req = 0;
    samp_in = 16'h0;
    for (int i = 0; i < DEPTH; i++) sram[i] = 16'h0;
    repeat (3) clk1();
    rst = 0;
    chk_reset_vals();

    fixed_q.push_back(16'h1234);
    fixed_q.push_back(16'hABCD);
    rec_session(2, 0);
    play_session(3, 0);
    rec_session(5, 0);
    play_session(5, 0);
    rec_session(2, 2);
    play_session(2, 0);
    reset_mid_write();

    for (int k = 0; k < 30; k++) begin
      rec_session($urandom_range(0, 6), $urandom_range(0, 1));
      play_session($urandom_range(0, 6), $urandom_range(0, 1));
    end

    chk("scoreboard_empty", 32'(sb.size()), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
